// File: rtl/udp_tx_pkg.sv
// Shared constants for the UDP transmit arbiter: FSM state codes, REQ timeout, counter width.
package udp_tx_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_REQ    = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DRAIN  = 2'd3;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Source-side and network-side signals of the UDP transmit arbiter.
// master = arbiter view, slave = sources/network view.
interface udp_tx_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    src_req;
  logic [N_SRC*16-1:0] src_length;
  logic [N_SRC*8-1:0]  src_data;
  logic [N_SRC-1:0]    src_rd;
  logic [N_SRC-1:0]    src_done;
  logic                udp_tx_request;
  logic [15:0]         udp_tx_length;
  logic [7:0]          udp_tx_data;
  logic [7:0]          port_ID;
  logic                udp_tx_enable;
  logic                udp_tx_active;

  modport master (
    input  src_req, src_length, src_data, udp_tx_enable, udp_tx_active,
    output src_rd, src_done, udp_tx_request, udp_tx_length, udp_tx_data, port_ID
  );

  modport slave (
    output src_req, src_length, src_data, udp_tx_enable, udp_tx_active,
    input  src_rd, src_done, udp_tx_request, udp_tx_length, udp_tx_data, port_ID
  );
endinterface

// File: rtl/udp_tx_grant.sv
// Source picker: fixed lowest-index priority, or round-robin from the last grant
// when UDP_TX_ARB_RR_EN is defined. Latches the grant when the arbiter takes it.
module udp_tx_grant #(
  parameter int N_SRC = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             take,
  output logic             pick_valid,
  output logic [IDX_W-1:0] pick_idx,
  output logic [N_SRC-1:0] pick_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] grant_idx_reg;

  assign pick_valid = |req;

`ifdef UDP_TX_ARB_RR_EN
  // Walk from last+N down to last+1 so the nearest successor of the last grant wins.
  always_comb begin
    pick_idx = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (req[(int'(grant_idx_reg) + k) % N_SRC]) begin
        pick_idx = IDX_W'((int'(grant_idx_reg) + k) % N_SRC);
      end
    end
  end
`else
  always_comb begin
    pick_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_onehot
      assign pick_onehot[gi] = pick_valid && (pick_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_idx_reg <= '0;
    end else if (take) begin
      grant_idx_reg <= pick_idx;
    end
  end

  assign grant_idx = grant_idx_reg;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Multi-source UDP transmit arbiter: grants one source, requests the network, streams
// payload behind the UDP header. Round-robin arbitration with UDP_TX_ARB_RR_EN.
module udp_tx_arbiter
  import udp_tx_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int PAYLOAD_OFFSET = 8,
  parameter int PORT_BASE      = 0
) (
  input logic              clock,
  input logic              reset,
  udp_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam logic [CNT_W-1:0] RD_START = CNT_W'(PAYLOAD_OFFSET - 1);
  localparam logic [CNT_W-1:0] OFF_END  = CNT_W'(PAYLOAD_OFFSET);

  state_t           state_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [CNT_W-1:0] offset_cnt_reg;
  logic [CNT_W-1:0] timeout_cnt_reg;
  logic [15:0]      len_reg;
  logic [7:0]       data_reg;
  logic [7:0]       port_reg;
  logic [N_SRC-1:0] done_reg;
  logic             active_prev_reg;

  logic [7:0]       data_arr [N_SRC];
  logic [15:0]      len_arr  [N_SRC];
  logic [N_SRC-1:0] grant_onehot;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] grant_idx;
  logic             pick_valid;
  logic             take;
  logic             active_fall;
  logic             rd_active;
  logic [15:0]      pick_len;
  logic [7:0]       grant_data;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign data_arr[gi]     = bus.src_data[8*gi +: 8];
      assign len_arr[gi]      = bus.src_length[16*gi +: 16];
      assign grant_onehot[gi] = (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // A source still holds src_req during its own src_done cycle; keep it out of that arbitration.
  assign eligible = bus.src_req & ~done_reg;
  assign take     = (state_reg == ST_IDLE) && pick_valid;

  udp_tx_grant #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_grant (
    .clock       (clock),
    .reset       (reset),
    .req         (eligible),
    .take        (take),
    .pick_valid  (pick_valid),
    .pick_idx    (pick_idx),
    .pick_onehot (pick_onehot),
    .grant_idx   (grant_idx)
  );

  assign pick_len    = len_arr[pick_idx];
  assign grant_data  = data_arr[grant_idx];
  assign active_fall = active_prev_reg && !bus.udp_tx_active;
  assign rd_active   = (state_reg == ST_STREAM) && (offset_cnt_reg >= RD_START) && !active_fall;

  assign bus.src_rd         = rd_active ? grant_onehot : '0;
  assign bus.src_done       = done_reg;
  assign bus.udp_tx_request = (state_reg == ST_REQ);
  assign bus.udp_tx_length  = len_reg;
  assign bus.udp_tx_data    = data_reg;
  assign bus.port_ID        = port_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      byte_cnt_reg    <= '0;
      offset_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      len_reg         <= '0;
      data_reg        <= '0;
      port_reg        <= '0;
      done_reg        <= '0;
      active_prev_reg <= 1'b0;
    end else begin
      done_reg        <= '0;
      active_prev_reg <= bus.udp_tx_active;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            if (pick_len == 16'd0) begin
              done_reg <= pick_onehot;
            end else begin
              state_reg       <= ST_REQ;
              len_reg         <= pick_len;
              port_reg        <= 8'(PORT_BASE + int'(pick_idx));
              timeout_cnt_reg <= '0;
            end
          end
        end
        ST_REQ: begin
          if (bus.udp_tx_enable) begin
            state_reg      <= ST_STREAM;
            byte_cnt_reg   <= '0;
            offset_cnt_reg <= CNT_W'(1);
          end else if (timeout_cnt_reg == TIMEOUT_CYCLES - CNT_W'(1)) begin
            state_reg <= ST_IDLE;
            done_reg  <= grant_onehot;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
          end
        end
        ST_STREAM: begin
          if (active_fall) begin
            state_reg <= ST_IDLE;
            done_reg  <= grant_onehot;
          end else begin
            if (offset_cnt_reg < OFF_END) begin
              offset_cnt_reg <= offset_cnt_reg + CNT_W'(1);
            end
            if (rd_active) begin
              data_reg <= grant_data;
              if (byte_cnt_reg == len_reg - 16'd1) begin
                state_reg <= ST_DRAIN;
              end else begin
                byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.udp_tx_active) begin
            state_reg <= ST_IDLE;
            done_reg  <= grant_onehot;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
